// File: rtl/tenant_merge.sv
// tenant_merge: packet-granular round-robin merge of the two per-tenant
// AXI4-Stream pipelines into one registered output stream with per-input packet counters.
module tenant_merge #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              axis_aclk,
    input  logic                              axis_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_0_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_0_tkeep,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   s_axis_0_tuser,
    input  logic                              s_axis_0_tvalid,
    input  logic                              s_axis_0_tlast,
    output logic                              s_axis_0_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_1_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_1_tkeep,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   s_axis_1_tuser,
    input  logic                              s_axis_1_tvalid,
    input  logic                              s_axis_1_tlast,
    output logic                              s_axis_1_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    output logic [31:0]                       pkt_cnt_0,
    output logic [31:0]                       pkt_cnt_1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_0 = 2'd1,
        SEND_1 = 2'd2
    } state_e;

    state_e                              state_q, state_d;
    logic                                lastGrant_q, lastGrant_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0]      tdata_q, tdata_d;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0]    tkeep_q, tkeep_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]     tuser_q, tuser_d;
    logic                                tvalid_q, tvalid_d;
    logic                                tlast_q, tlast_d;
    logic [31:0]                         pktCnt0_q, pktCnt0_d;
    logic [31:0]                         pktCnt1_q, pktCnt1_d;
    logic                                outSpace;
    logic                                ready0, ready1;
    logic                                take0, take1;

    // Grant is decided only in IDLE, so a packet in flight can never be preempted;
    // on a tie the input that did not win last time is chosen.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        ready0      = 1'b0;
        ready1      = 1'b0;
        outSpace    = !tvalid_q || m_axis_tready;
        case (state_q)
            IDLE: begin
                if (s_axis_0_tvalid && (!s_axis_1_tvalid || lastGrant_q)) begin
                    state_d     = SEND_0;
                    lastGrant_d = 1'b0;
                end else if (s_axis_1_tvalid) begin
                    state_d     = SEND_1;
                    lastGrant_d = 1'b1;
                end
            end
            SEND_0: begin
                ready0 = outSpace;
                if (s_axis_0_tvalid && outSpace && s_axis_0_tlast) begin
                    state_d = IDLE;
                end
            end
            SEND_1: begin
                ready1 = outSpace;
                if (s_axis_1_tvalid && outSpace && s_axis_1_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        take0 = s_axis_0_tvalid && ready0;
        take1 = s_axis_1_tvalid && ready1;
    end

    always_comb begin
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tuser_d   = tuser_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        pktCnt0_d = pktCnt0_q;
        pktCnt1_d = pktCnt1_q;
        if (take0) begin
            tdata_d  = s_axis_0_tdata;
            tkeep_d  = s_axis_0_tkeep;
            tuser_d  = s_axis_0_tuser;
            tlast_d  = s_axis_0_tlast;
            tvalid_d = 1'b1;
            if (s_axis_0_tlast) pktCnt0_d = pktCnt0_q + 32'd1;
        end else if (take1) begin
            tdata_d  = s_axis_1_tdata;
            tkeep_d  = s_axis_1_tkeep;
            tuser_d  = s_axis_1_tuser;
            tlast_d  = s_axis_1_tlast;
            tvalid_d = 1'b1;
            if (s_axis_1_tlast) pktCnt1_d = pktCnt1_q + 32'd1;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // lastGrant resets to 1 so that input 0 wins the first tie after reset.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tuser_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            pktCnt0_q   <= '0;
            pktCnt1_q   <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tuser_q     <= tuser_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            pktCnt0_q   <= pktCnt0_d;
            pktCnt1_q   <= pktCnt1_d;
        end
    end

    assign s_axis_0_tready = ready0;
    assign s_axis_1_tready = ready1;
    assign m_axis_tdata    = tdata_q;
    assign m_axis_tkeep    = tkeep_q;
    assign m_axis_tuser    = tuser_q;
    assign m_axis_tvalid   = tvalid_q;
    assign m_axis_tlast    = tlast_q;
    assign pkt_cnt_0       = pktCnt0_q;
    assign pkt_cnt_1       = pktCnt1_q;

endmodule

// File: tb/tb_tenant_merge.sv
// tb_tenant_merge: directed and randomized packet traffic for tenant_merge,
// checked against a packet-order scoreboard built when the packets are generated.
module tb_tenant_merge;

    localparam int DW = 256;
    localparam int KW = DW / 8;
    localparam int UW = 128;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s0Tdata, s1Tdata, mTdata;
    logic [KW-1:0] s0Tkeep, s1Tkeep, mTkeep;
    logic [UW-1:0] s0Tuser, s1Tuser, mTuser;
    logic          s0Tvalid, s0Tlast, s0Tready;
    logic          s1Tvalid, s1Tlast, s1Tready;
    logic          mTvalid, mTlast, mTready;
    logic [31:0]   pktCnt0, pktCnt1;

    int    checks = 0;
    int    errors = 0;
    int    cycle  = 0;
    beat_t q0[$];
    beat_t q1[$];
    beat_t expQ[$];
    int    rxCycle[$];
    int    rxCount = 0;
    int    expCnt0 = 0;
    int    expCnt1 = 0;
    bit    en0 = 1'b0;
    bit    en1 = 1'b0;
    int    rate = 100;
    int    readyMode = 0;

    tenant_merge dut (
        .axis_aclk       (clk),
        .axis_resetn     (rst_n),
        .s_axis_0_tdata  (s0Tdata),
        .s_axis_0_tkeep  (s0Tkeep),
        .s_axis_0_tuser  (s0Tuser),
        .s_axis_0_tvalid (s0Tvalid),
        .s_axis_0_tlast  (s0Tlast),
        .s_axis_0_tready (s0Tready),
        .s_axis_1_tdata  (s1Tdata),
        .s_axis_1_tkeep  (s1Tkeep),
        .s_axis_1_tuser  (s1Tuser),
        .s_axis_1_tvalid (s1Tvalid),
        .s_axis_1_tlast  (s1Tlast),
        .s_axis_1_tready (s1Tready),
        .m_axis_tdata    (mTdata),
        .m_axis_tkeep    (mTkeep),
        .m_axis_tuser    (mTuser),
        .m_axis_tvalid   (mTvalid),
        .m_axis_tlast    (mTlast),
        .m_axis_tready   (mTready),
        .pkt_cnt_0       (pktCnt0),
        .pkt_cnt_1       (pktCnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Builds one packet for a source; the call order is the expected output order.
    task automatic applyStimulus(input int src, input int len, input bit seqData);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
            if (seqData) b.data = DW'(i + 1);
            b.keep = KW'($urandom);
            for (int w = 0; w < UW / 32; w++) b.user[w*32 +: 32] = $urandom;
            b.user[39:32] = 8'(src);
            b.last = (i == len - 1);
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
            expQ.push_back(b);
        end
        if (src == 0) expCnt0++;
        else          expCnt1++;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        en0 = 1'b0;
        en1 = 1'b0;
        readyMode = 0;
        rate = 100;
        q0.delete();
        q1.delete();
        expQ.delete();
        rxCycle.delete();
        rxCount = 0;
        expCnt0 = 0;
        expCnt1 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitDrain(input string tag, input int maxCyc);
        int n = 0;
        while (expQ.size() > 0 && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (expQ.size() == 0) else begin
            errors++;
            $error("FAIL %s_timeout: observed %0d beats pending expected 0", tag, expQ.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, "_cnt0"}, 512'(pktCnt0), 512'(expCnt0));
        checkOutput({tag, "_cnt1"}, 512'(pktCnt1), 512'(expCnt1));
    endtask

    // Source drivers: hold a beat until it is accepted, then present the next one.
    initial begin : drv0
        bit fire;
        s0Tvalid = 1'b0;
        {s0Tdata, s0Tkeep, s0Tuser, s0Tlast} = '0;
        forever begin
            @(negedge clk);
            fire = s0Tvalid && s0Tready;
            @(posedge clk);
            #1;
            if (fire && q0.size() > 0) void'(q0.pop_front());
            if (!rst_n || !en0) begin
                s0Tvalid = 1'b0;
            end else if (fire || !s0Tvalid) begin
                if (q0.size() > 0 && $urandom_range(0, 99) < rate) begin
                    s0Tvalid = 1'b1;
                    {s0Tdata, s0Tkeep, s0Tuser, s0Tlast} = q0[0];
                end else begin
                    s0Tvalid = 1'b0;
                end
            end
        end
    end

    initial begin : drv1
        bit fire;
        s1Tvalid = 1'b0;
        {s1Tdata, s1Tkeep, s1Tuser, s1Tlast} = '0;
        forever begin
            @(negedge clk);
            fire = s1Tvalid && s1Tready;
            @(posedge clk);
            #1;
            if (fire && q1.size() > 0) void'(q1.pop_front());
            if (!rst_n || !en1) begin
                s1Tvalid = 1'b0;
            end else if (fire || !s1Tvalid) begin
                if (q1.size() > 0 && $urandom_range(0, 99) < rate) begin
                    s1Tvalid = 1'b1;
                    {s1Tdata, s1Tkeep, s1Tuser, s1Tlast} = q1[0];
                end else begin
                    s1Tvalid = 1'b0;
                end
            end
        end
    end

    // Downstream ready: always on, random, or the repeating 1,0,0,1 pattern.
    initial begin : readyDrv
        logic [3:0] pat;
        int patIdx;
        pat = 4'b1001;
        patIdx = 0;
        mTready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                1:       mTready = 1'($urandom_range(0, 1));
                2: begin
                    mTready = pat[patIdx % 4];
                    patIdx++;
                end
                default: mTready = 1'b1;
            endcase
        end
    end

    // Output monitor: scoreboard on every transfer, plus AXI hold and stall rules.
    initial begin : monitor
        beat_t cur, prev;
        bit prevStall;
        prevStall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {mTdata, mTkeep, mTuser, mTlast};
            if (!rst_n) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall) checkOutput("hold_stable", {mTvalid, cur}, {1'b1, prev});
                if (mTvalid && !mTready) checkOutput("stall_tready", {s0Tready, s1Tready}, 2'b00);
                if (mTvalid && mTready) begin
                    checks++;
                    assert (expQ.size() > 0) else begin
                        errors++;
                        $error("FAIL unexpected_beat: observed %0h expected none", cur);
                    end
                    if (expQ.size() > 0) checkOutput("beat", cur, expQ.pop_front());
                    rxCycle.push_back(cycle);
                    rxCount++;
                end
                prevStall = mTvalid && !mTready;
                prev = cur;
            end
        end
    end

    initial begin : main
        int n, c0, c1;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        $display("[TB] reset state");
        checkOutput("reset_outputs", {mTvalid, mTlast, mTdata, mTkeep, mTuser}, '0);
        checkOutput("reset_tready", {s0Tready, s1Tready}, 2'b00);
        checkOutput("reset_cnt", {pktCnt0, pktCnt1}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single packet from input 0");
        applyStimulus(0, 4, 1'b1);
        en0 = 1'b1;
        n = 0;
        while (!s0Tvalid && n < 20) begin @(negedge clk); n++; end
        c0 = cycle;
        n = 0;
        while (!mTvalid && n < 20) begin @(negedge clk); n++; end
        c1 = cycle;
        checkOutput("first_latency", 512'(c1 - c0), 512'd2);
        waitDrain("single", 100);
        checkOutput("single_contig", 512'(rxCycle[3] - rxCycle[0]), 512'd3);
        checkCounts("single");

        $display("[TB] round-robin");
        applyReset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 3, 1'b0);
            applyStimulus(1, 3, 1'b0);
        end
        en0 = 1'b1;
        en1 = 1'b1;
        waitDrain("rr", 200);
        checkCounts("rr");

        $display("[TB] backpressure");
        applyReset();
        readyMode = 2;
        applyStimulus(1, 5, 1'b0);
        en1 = 1'b1;
        waitDrain("bp", 200);
        checkCounts("bp");

        $display("[TB] preemption attempt");
        applyReset();
        applyStimulus(0, 8, 1'b0);
        applyStimulus(1, 2, 1'b0);
        en0 = 1'b1;
        repeat (4) @(negedge clk);
        en1 = 1'b1;
        waitDrain("preempt", 200);
        checkOutput("preempt_contig", 512'(rxCycle[7] - rxCycle[0]), 512'd7);
        checkOutput("preempt_bubble", 512'(rxCycle[8] - rxCycle[7]), 512'd2);
        checkCounts("preempt");

        $display("[TB] reset mid-packet");
        applyReset();
        applyStimulus(0, 6, 1'b0);
        en0 = 1'b1;
        n = 0;
        while (rxCount < 2 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        en0 = 1'b0;
        q0.delete();
        expQ.delete();
        #1;
        checkOutput("midrst_outputs", {mTvalid, mTlast, mTdata, mTkeep, mTuser}, '0);
        checkOutput("midrst_tready", {s0Tready, s1Tready}, 2'b00);
        checkOutput("midrst_cnt", {pktCnt0, pktCnt1}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expCnt0 = 0;
        expCnt1 = 0;
        @(negedge clk);
        applyStimulus(1, 3, 1'b0);
        en1 = 1'b1;
        waitDrain("midrst", 100);
        checkCounts("midrst");

        $display("[TB] single-beat packets");
        applyReset();
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 1'b0);
        en1 = 1'b1;
        waitDrain("onebeat", 200);
        for (int i = 1; i < 10; i++) checkOutput("onebeat_gap", 512'(rxCycle[i] - rxCycle[i-1]), 512'd2);
        checkCounts("onebeat");

        $display("[TB] random round-robin with backpressure");
        applyReset();
        readyMode = 1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, $urandom_range(1, 6), 1'b0);
            applyStimulus(1, $urandom_range(1, 6), 1'b0);
        end
        en0 = 1'b1;
        en1 = 1'b1;
        waitDrain("rand_rr", 2000);
        checkCounts("rand_rr");

        $display("[TB] random lone source with gaps");
        applyReset();
        readyMode = 1;
        rate = 60;
        for (int i = 0; i < 8; i++) applyStimulus(0, $urandom_range(1, 5), 1'b0);
        en0 = 1'b1;
        waitDrain("rand_lone", 2000);
        checkCounts("rand_lone");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
